// File: rtl/display_pkg.sv
// Shared types and constants for the eight-digit seven-segment display.
package display_pkg;

  localparam int unsigned NUM_DIGITS = 8;

  typedef logic [2:0]            digit_idx_t;
  typedef logic [6:0]            seg_t;
  typedef logic [NUM_DIGITS-1:0] an_t;

  // Active-low: all segments and all anodes dark.
  localparam seg_t SEG_OFF = 7'h7F;
  localparam an_t  AN_OFF  = 8'hFF;

endpackage

// File: rtl/seven_segment_controller_if.sv
// Load port and display outputs of the seven-segment scan controller.
interface seven_segment_controller_if;

  logic [31:0]                     val_in;
  logic                            val_valid_in;
  logic [7:0]                      dig_en_in;
  logic                            lz_blank_in;
  logic                            load_ready_out;
  display_pkg::seg_t               cat_out;
  display_pkg::an_t                an_out;
  logic                            frame_out;

  modport master (
    output val_in,
    output val_valid_in,
    output dig_en_in,
    output lz_blank_in,
    input  load_ready_out,
    input  cat_out,
    input  an_out,
    input  frame_out
  );

  modport slave (
    input  val_in,
    input  val_valid_in,
    input  dig_en_in,
    input  lz_blank_in,
    output load_ready_out,
    output cat_out,
    output an_out,
    output frame_out
  );

endinterface

// File: rtl/bto7s.sv
// Nibble to seven-segment decoder; active-high segments, bit order {g,f,e,d,c,b,a}.
module bto7s (
  input  logic [3:0] x_in,
  output logic [6:0] s_out
);

  always_comb begin
    unique case (x_in)
      4'h0: s_out = 7'h3F;
      4'h1: s_out = 7'h06;
      4'h2: s_out = 7'h5B;
      4'h3: s_out = 7'h4F;
      4'h4: s_out = 7'h66;
      4'h5: s_out = 7'h6D;
      4'h6: s_out = 7'h7D;
      4'h7: s_out = 7'h07;
      4'h8: s_out = 7'h7F;
      4'h9: s_out = 7'h6F;
      4'hA: s_out = 7'h77;
      4'hB: s_out = 7'h7C;
      4'hC: s_out = 7'h39;
      4'hD: s_out = 7'h5E;
      4'hE: s_out = 7'h79;
      4'hF: s_out = 7'h71;
    endcase
  end

endmodule

// File: rtl/seven_segment_controller.sv
// Time-multiplexed eight-digit scan controller with anti-ghost blanking, digit mask,
// leading-zero blanking and frame-synchronous value updates.
module seven_segment_controller
  import display_pkg::*;
#(
  parameter int unsigned COUNT_PERIOD = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  seven_segment_controller_if.slave   bus
);

  localparam int unsigned CntW = (COUNT_PERIOD > 1) ? $clog2(COUNT_PERIOD) : 1;
  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t       CntLast  = cnt_t'(COUNT_PERIOD - 1);
  localparam cnt_t       BlankEnd = cnt_t'(BLANK_CYCLES);
  localparam digit_idx_t IdxLast  = digit_idx_t'(NUM_DIGITS - 1);

  cnt_t        cnt_q, cnt_d;
  digit_idx_t  idx_q, idx_d;
  logic        frame_q;
  an_t         an_q, an_d;
  seg_t        cat_q, cat_d;

  logic [31:0] act_val_q, pend_val_q;
  logic [7:0]  act_en_q, pend_en_q;
  logic        act_lz_q, pend_lz_q;
  logic        pend_q, pend_d;

  logic        cnt_wrap, boundary, load_fire;
  logic [3:0]  nibble;
  seg_t        seg_on;
  logic [NUM_DIGITS-1:1] zero_above;
  logic [NUM_DIGITS-1:0] lz_blank;

  assign cnt_wrap  = (cnt_q == CntLast);
  assign boundary  = cnt_wrap && (idx_q == IdxLast);
  assign load_fire = bus.val_valid_in && !pend_q;

  assign cnt_d = cnt_wrap ? '0 : cnt_q + cnt_t'(1);
  assign idx_d = cnt_wrap ? idx_q + digit_idx_t'(1) : idx_q;

  // Capture and apply are mutually exclusive on one edge, so a capture that lands on a
  // boundary edge waits for the next boundary.
  always_comb begin
    pend_d = pend_q;
    if (boundary && pend_q) pend_d = 1'b0;
    if (load_fire)          pend_d = 1'b1;
  end

  // zero_above[i]: nibbles i..7 of the active value are all zero.
  always_comb begin
    zero_above = '0;
    lz_blank   = '0;
    zero_above[NUM_DIGITS-1] = (act_val_q[31:28] == 4'h0);
    for (int i = NUM_DIGITS - 2; i >= 1; i--) begin
      zero_above[i] = zero_above[i+1] && (act_val_q[4*i +: 4] == 4'h0);
    end
    for (int i = 1; i < NUM_DIGITS; i++) begin
      lz_blank[i] = act_lz_q && zero_above[i];
    end
  end

  assign nibble = act_val_q[{idx_q, 2'b00} +: 4];

  bto7s u_bto7s (
    .x_in  (nibble),
    .s_out (seg_on)
  );

  always_comb begin
    an_d  = AN_OFF;
    cat_d = SEG_OFF;
    if ((cnt_q >= BlankEnd) && act_en_q[idx_q] && !lz_blank[idx_q]) begin
      an_d  = ~(an_t'(1) << idx_q);
      cat_d = ~seg_on;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      frame_q    <= 1'b0;
      an_q       <= AN_OFF;
      cat_q      <= SEG_OFF;
      act_val_q  <= '0;
      act_en_q   <= '0;
      act_lz_q   <= 1'b0;
      pend_val_q <= '0;
      pend_en_q  <= '0;
      pend_lz_q  <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frame_q <= boundary;
      an_q    <= an_d;
      cat_q   <= cat_d;
      pend_q  <= pend_d;
      if (load_fire) begin
        pend_val_q <= bus.val_in;
        pend_en_q  <= bus.dig_en_in;
        pend_lz_q  <= bus.lz_blank_in;
      end
      if (boundary && pend_q) begin
        act_val_q <= pend_val_q;
        act_en_q  <= pend_en_q;
        act_lz_q  <= pend_lz_q;
      end
    end
  end

  assign bus.load_ready_out = !pend_q;
  assign bus.an_out         = an_q;
  assign bus.cat_out        = cat_q;
  assign bus.frame_out      = frame_q;

endmodule

// File: tb/tb_seven_segment_controller.sv
// Directed bench for seven_segment_controller with COUNT_PERIOD=4, BLANK_CYCLES=1.
module tb_seven_segment_controller;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  seven_segment_controller_if bus ();

  seven_segment_controller #(
    .COUNT_PERIOD (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Active-low cathodes {g,f,e,d,c,b,a}, worked out by hand per glyph.
  function automatic logic [6:0] exp_cat(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic wait_frame(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.frame_out) seen = 1'b1;
    end
    if (!seen) check({tag, "_frame_timeout"}, 32'd0, 32'd1);
  endtask

  // Entered on the negedge just after a boundary edge; walks one full frame.
  task automatic check_frame(input string tag, input logic [31:0] val, input logic [7:0] en,
                             input logic lz);
    for (int k = 0; k < 32; k++) begin
      int d;
      int c;
      logic lit;
      logic [3:0] nib;
      logic [7:0] ea;
      logic [6:0] ec;
      @(negedge clk);
      d   = k / 4;
      c   = k % 4;
      nib = val[4*d +: 4];
      lit = (c != 0) && en[d] && !(lz && (d != 0) && ((val >> (4*d)) == 32'd0));
      ea  = lit ? (8'hFF ^ (8'h01 << d)) : 8'hFF;
      ec  = lit ? exp_cat(nib) : 7'h7F;
      check($sformatf("%s_an_k%0d", tag, k), {24'd0, bus.an_out}, {24'd0, ea});
      check($sformatf("%s_cat_k%0d", tag, k), {25'd0, bus.cat_out}, {25'd0, ec});
      check($sformatf("%s_frame_k%0d", tag, k), {31'd0, bus.frame_out}, {31'd0, k == 31});
    end
  endtask

  task automatic do_load(input logic [31:0] val, input logic [7:0] en, input logic lz);
    bus.val_in       = val;
    bus.dig_en_in    = en;
    bus.lz_blank_in  = lz;
    bus.val_valid_in = 1'b1;
    @(negedge clk);
    bus.val_valid_in = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.val_in = '0;
    bus.val_valid_in = 1'b0;
    bus.dig_en_in = '0;
    bus.lz_blank_in = 1'b0;

    // Reset state and one idle frame.
    repeat (3) @(negedge clk);
    check("rst_an", {24'd0, bus.an_out}, 32'hFF);
    check("rst_cat", {25'd0, bus.cat_out}, 32'h7F);
    check("rst_frame", {31'd0, bus.frame_out}, 32'd0);
    check("rst_ready", {31'd0, bus.load_ready_out}, 32'd1);
    rst = 1'b0;
    wait_frame("idle");
    check_frame("idle", 32'h0, 8'h00, 1'b0);

    // Basic display.
    do_load(32'h0000_00A5, 8'hFF, 1'b0);
    check("basic_ready_drop", {31'd0, bus.load_ready_out}, 32'd0);
    wait_frame("basic");
    check("basic_ready_back", {31'd0, bus.load_ready_out}, 32'd1);
    check_frame("basic", 32'h0000_00A5, 8'hFF, 1'b0);

    // Leading-zero blanking.
    do_load(32'h0000_0000, 8'hFF, 1'b1);
    wait_frame("lz0");
    check_frame("lz0", 32'h0000_0000, 8'hFF, 1'b1);
    do_load(32'h0001_0000, 8'hFF, 1'b1);
    wait_frame("lz4");
    check_frame("lz4", 32'h0001_0000, 8'hFF, 1'b1);

    // Handshake: a strobe while not ready is dropped.
    do_load(32'h1111_1111, 8'hFF, 1'b0);
    do_load(32'h2222_2222, 8'hFF, 1'b0);
    wait_frame("hs1");
    check_frame("hs1", 32'h1111_1111, 8'hFF, 1'b0);
    check("hs_ready", {31'd0, bus.load_ready_out}, 32'd1);
    do_load(32'h2222_2222, 8'hFF, 1'b0);
    wait_frame("hs2");
    check_frame("hs2", 32'h2222_2222, 8'hFF, 1'b0);

    // Capture on the boundary edge itself is deferred one frame.
    repeat (31) @(negedge clk);
    do_load(32'h3333_3333, 8'hFF, 1'b0);
    check("coll_frame", {31'd0, bus.frame_out}, 32'd1);
    check("coll_ready", {31'd0, bus.load_ready_out}, 32'd0);
    check_frame("coll_old", 32'h2222_2222, 8'hFF, 1'b0);
    check("coll_apply_ready", {31'd0, bus.load_ready_out}, 32'd1);
    check_frame("coll_new", 32'h3333_3333, 8'hFF, 1'b0);

    // Mask, then reset mid-slot with a load pending.
    do_load(32'h8765_4321, 8'h0F, 1'b0);
    wait_frame("mask");
    check_frame("mask", 32'h8765_4321, 8'h0F, 1'b0);
    do_load(32'h9999_9999, 8'hFF, 1'b0);
    check("pend_ready", {31'd0, bus.load_ready_out}, 32'd0);
    @(negedge clk);
    check("pre_rst_an", {24'd0, bus.an_out}, 32'hFE);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_an", {24'd0, bus.an_out}, 32'hFF);
    check("mid_rst_cat", {25'd0, bus.cat_out}, 32'h7F);
    check("mid_rst_frame", {31'd0, bus.frame_out}, 32'd0);
    check("mid_rst_ready", {31'd0, bus.load_ready_out}, 32'd1);
    wait_frame("post_rst");
    check_frame("post_rst", 32'h0, 8'h00, 1'b0);
    check("post_rst_ready", {31'd0, bus.load_ready_out}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
